// File: rtl/clock_period_meter.sv
// -----------------------------------------------------------------------------
// clock_period_meter
//
// Receive/check end for the clock-divider outputs. Samples a divided clock
// (div_in) in the clk_in domain and measures how many clk_in cycles the
// sampled level stays high and low. The sum is the period. A run of LOCK_N
// identical periods asserts locked. If no expected edge arrives within
// TIMEOUT cycles, stuck is raised and held.
//
// Ports
//   clk_in      system clock
//   rst         asynchronous reset, active low
//   clear       synchronous clear, active high; same effect as rst
//   div_in      divided clock under test (asynchronous to nothing, but
//               only sampled on clk_in rising edges)
//   period      last published high_time + low_time, saturating
//   high_time   last published high duration (clk_in cycles)
//   low_time    last published low duration (clk_in cycles)
//   meas_valid  one-cycle pulse when a new measurement is published
//   locked      LOCK_N consecutive publishes carried the same period
//   stuck       no expected edge within TIMEOUT cycles; sticky until the
//               next rise, clear or rst
//   state_dbg   current measurement state (0 IDLE, 1 HIGH, 2 LOW)
//
// Handshake: meas_valid is a push-only strobe. There is no ready input.
// period/high_time/low_time are stable from the meas_valid cycle until the
// next publish, so a consumer may sample them any time after the strobe.
// -----------------------------------------------------------------------------
module clock_period_meter #(
    parameter int CNT_W   = 8,
    parameter int LOCK_N  = 4,
    parameter int TIMEOUT = 255
) (
    input  logic             clk_in,
    input  logic             rst,
    input  logic             clear,
    input  logic             div_in,
    output logic [CNT_W-1:0] period,
    output logic [CNT_W-1:0] high_time,
    output logic [CNT_W-1:0] low_time,
    output logic             meas_valid,
    output logic             locked,
    output logic             stuck,
    output logic [1:0]       state_dbg
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_HIGH = 2'd1,
        ST_LOW  = 2'd2
    } state_t;

    localparam logic [CNT_W-1:0] TIMEOUT_C = CNT_W'(TIMEOUT);
    localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);
    localparam logic [3:0]       RUN_MAX   = 4'(LOCK_N);

    state_t           state;
    state_t           state_nxt;

    logic             s1;
    logic             s2;
    logic             rise;
    logic             fall;

    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] hcnt;
    logic [CNT_W-1:0] lcnt;
    logic [3:0]       run;

    logic             publish;
    logic             timeout;
    logic [CNT_W:0]   sum;
    logic [CNT_W-1:0] new_period;

    // Edges are judged on the already-registered copy, so each duration is
    // the number of cycles s1 held its level.
    assign rise = s1 & ~s2;
    assign fall = ~s1 & s2;

    assign sum        = {1'b0, hcnt} + {1'b0, lcnt};
    assign new_period = sum[CNT_W] ? {CNT_W{1'b1}} : sum[CNT_W-1:0];

    assign locked    = (run == RUN_MAX);
    assign state_dbg = state;

    // -------------------------------------------------------------------------
    // State register
    // -------------------------------------------------------------------------
    always_ff @(posedge clk_in or negedge rst) begin
        if (!rst) begin
            state <= ST_IDLE;
        end else if (clear) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // -------------------------------------------------------------------------
    // Next state. An edge always beats a timeout in the same cycle.
    // -------------------------------------------------------------------------
    always_comb begin
        state_nxt = state;
        publish   = 1'b0;
        timeout   = 1'b0;
        case (state)
            ST_IDLE: begin
                if (rise) begin
                    state_nxt = ST_HIGH;
                end else if (cnt == TIMEOUT_C) begin
                    timeout = 1'b1;
                end
            end
            ST_HIGH: begin
                if (fall) begin
                    state_nxt = ST_LOW;
                end else if (hcnt == TIMEOUT_C) begin
                    timeout   = 1'b1;
                    state_nxt = ST_IDLE;
                end
            end
            ST_LOW: begin
                if (rise) begin
                    publish   = 1'b1;
                    state_nxt = ST_HIGH;
                end else if (lcnt == TIMEOUT_C) begin
                    timeout   = 1'b1;
                    state_nxt = ST_IDLE;
                end
            end
            default: begin
                state_nxt = ST_IDLE;
            end
        endcase
    end

    // -------------------------------------------------------------------------
    // Sampling, counters, published results, lock run and stuck flag
    // -------------------------------------------------------------------------
    always_ff @(posedge clk_in or negedge rst) begin
        if (!rst) begin
            s1         <= 1'b0;
            s2         <= 1'b0;
            cnt        <= '0;
            hcnt       <= '0;
            lcnt       <= '0;
            run        <= '0;
            period     <= '0;
            high_time  <= '0;
            low_time   <= '0;
            meas_valid <= 1'b0;
            stuck      <= 1'b0;
        end else if (clear) begin
            s1         <= 1'b0;
            s2         <= 1'b0;
            cnt        <= '0;
            hcnt       <= '0;
            lcnt       <= '0;
            run        <= '0;
            period     <= '0;
            high_time  <= '0;
            low_time   <= '0;
            meas_valid <= 1'b0;
            stuck      <= 1'b0;
        end else begin
            s1         <= div_in;
            s2         <= s1;
            meas_valid <= publish;

            case (state)
                ST_IDLE: begin
                    if (rise) begin
                        hcnt <= CNT_ONE;
                        cnt  <= '0;
                    end else if (timeout) begin
                        cnt  <= '0;
                    end else begin
                        cnt  <= cnt + CNT_ONE;
                    end
                end
                ST_HIGH: begin
                    if (fall) begin
                        lcnt <= CNT_ONE;
                    end else if (!timeout) begin
                        hcnt <= hcnt + CNT_ONE;
                    end
                end
                ST_LOW: begin
                    if (rise) begin
                        hcnt <= CNT_ONE;
                    end else if (!timeout) begin
                        lcnt <= lcnt + CNT_ONE;
                    end
                end
                default: begin
                    cnt <= '0;
                end
            endcase

            if (publish) begin
                high_time <= hcnt;
                low_time  <= lcnt;
                period    <= new_period;
                // Compare against the period still held from the last publish.
                if (run == 4'd0 || new_period != period) begin
                    run <= 4'd1;
                end else if (run != RUN_MAX) begin
                    run <= run + 4'd1;
                end
            end

            if (rise) begin
                stuck <= 1'b0;
            end else if (timeout) begin
                stuck <= 1'b1;
                run   <= '0;
            end
        end
    end

endmodule
